sumador_segmentado: RTL and testbench
=====================================

SUMADOR_SEGMENTADO -- requirements
Module: sumador_segmentado

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 2: number of pipeline stages; SHALL be >= 1 and divide WIDTH exactly; slice width SW = WIDTH/STAGES.
REQ-003 Parameter PwrC, default 0: power-annotation constant carried for power analysis; SHALL have no functional effect.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_L  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  operand set presented.
REQ-007 in_ready  output  1  block accepts operands this cycle.
REQ-008 a  input  WIDTH  operand A, two's complement or unsigned.
REQ-009 b  input  WIDTH  operand B.
REQ-010 ci  input  1  carry-in; used only when sub=0.
REQ-011 sub  input  1  0 = A+B+ci; 1 = A-B, computed as A+~B+1.
REQ-012 out_valid  output  1  result presented.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 s  output  WIDTH  sum/difference.
REQ-015 co  output  1  carry-out of the MSB.
REQ-016 ovf  output  1  signed overflow flag.

Function
REQ-017 Transfer in: an operand set SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; out: a result SHALL be consumed on a rising edge where out_valid=1 and out_ready=1.
REQ-018 Stage k (0..STAGES-1) SHALL add bit slice [k*SW +: SW] of A and the effective B, plus the carry registered from stage k-1; stage 0 SHALL use ci, or 1 when sub=1.
REQ-019 Effective B SHALL be b when sub=0 and ~b when sub=1; the operand slices not yet summed SHALL be carried forward in skew registers with the partial sum.
REQ-020 Each stage SHALL hold a valid bit; the pipeline SHALL advance all stages together when adv = !out_valid | out_ready.
REQ-021 in_ready SHALL equal adv; combinational paths from out_ready to in_ready are allowed.
REQ-022 Latency: a set accepted on edge N SHALL present out_valid=1 after edge N+STAGES-1 if adv is held at 1; throughput one result per cycle.
REQ-023 While out_valid=1 and out_ready=0, s, co, ovf, out_valid and all internal stage contents SHALL hold unchanged; no operands are accepted.
REQ-024 Stages whose valid bit is 0 (bubbles) SHALL advance like any stage; a bubble SHALL never raise out_valid.
REQ-025 co SHALL be the carry out of bit WIDTH-1; for sub=1, co=1 means no borrow (A >= B unsigned).
REQ-026 ovf SHALL be 1 when A and effective B have the same MSB and s MSB differs from it.
REQ-027 s, co and ovf SHALL be registered outputs of the last stage; results SHALL leave in acceptance order.
REQ-028 With STAGES=1 the block SHALL degenerate to a single registered full-width adder with the same handshake.

Reset
REQ-029 reset_L=0 SHALL immediately clear all stage valid bits, partial sums, carries and skew registers, independent of clk.
REQ-030 During and after reset: out_valid=0, s=0, co=0, ovf=0, in_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight results with no partial output; the first accepted set after release SHALL follow REQ-022.
REQ-032 Release of reset_L SHALL be synchronised by the integrator; the block SHALL not accept operands on the edge at which reset_L is still 0.

Verification (WIDTH=8, STAGES=2, out_ready=1 unless stated)
REQ-033 a=0xFF, b=0x01, ci=0, sub=0 accepted at edge N -> after edge N+1: s=0x00, co=1, ovf=0, out_valid=1.
REQ-034 a=0x7F, b=0x01, ci=0, sub=0 -> s=0x80, co=0, ovf=1; a=0x05, b=0x07, sub=1 -> s=0xFE, co=0, ovf=0.
REQ-035 Back-to-back sets 0x10+0x20, 0x30+0x40, 0xF0+0x20+ci, 0x80-0x01 on 4 consecutive edges -> outputs 0x30, 0x70, 0x11 (co=1), 0x7F (co=1, ovf=1) on 4 consecutive cycles, in order.
REQ-036 out_ready=0 for 3 cycles while out_valid=1 and a second set is in flight -> in_ready=0 and s/co/ovf stable for the whole stall; both results emerge unchanged and in order after out_ready=1.
REQ-037 reset_L pulsed low while two sets are in flight -> out_valid=0, s=0 immediately; no stale result appears after release; a new set 0x01+0x01 yields s=0x02 at the normal latency.
REQ-038 Randomised sweep for STAGES in {1,2,4,8} with random in_valid/out_ready -> every result matches A+B+ci or A-B, including co and ovf, with no loss, duplication or reordering.

Source files
------------

// File: rtl/sumador_segmentado.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sumador_segmentado: valid/ready pipelined adder/subtractor, STAGES slices |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sumador_segmentado #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int PwrC   = 0
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ovf
);

  localparam int c_sw         = WIDTH / STAGES;
  localparam int c_pwr_unused = PwrC;

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] sum_q   [STAGES];
  logic             cy_q    [STAGES];
  logic             ovf_q;

  logic             valid_d [STAGES];
  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] b_d     [STAGES];
  logic [WIDTH-1:0] sum_d   [STAGES];
  logic             cy_d    [STAGES];
  logic             ovf_d;

  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic             w_cy_in  [STAGES];
  logic             w_adv;

  assign w_adv     = !valid_q[STAGES-1] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = valid_q[STAGES-1];
  assign s         = sum_q[STAGES-1];
  assign co        = cy_q[STAGES-1];
  assign ovf       = ovf_q;

  // Operands travel whole through the skew registers so the last stage still
  // sees the MSBs of A and effective B when it forms the overflow flag.
  always_comb begin
    logic [c_sw:0] w_slice;
    w_slice     = '0;
    a_d[0]      = a;
    b_d[0]      = sub ? ~b : b;
    valid_d[0]  = in_valid;
    w_sum_in[0] = '0;
    w_cy_in[0]  = sub | ci;
    for (int k = 1; k < STAGES; k++) begin
      a_d[k]      = a_q[k-1];
      b_d[k]      = b_q[k-1];
      valid_d[k]  = valid_q[k-1];
      w_sum_in[k] = sum_q[k-1];
      w_cy_in[k]  = cy_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_slice = {1'b0, a_d[k][k*c_sw +: c_sw]}
              + {1'b0, b_d[k][k*c_sw +: c_sw]}
              + {{c_sw{1'b0}}, w_cy_in[k]};
      sum_d[k] = w_sum_in[k];
      sum_d[k][k*c_sw +: c_sw] = w_slice[c_sw-1:0];
      cy_d[k] = w_slice[c_sw];
    end
    ovf_d = (a_d[STAGES-1][WIDTH-1] == b_d[STAGES-1][WIDTH-1]) &&
            (sum_d[STAGES-1][WIDTH-1] != a_d[STAGES-1][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
        sum_q[k]   <= '0;
        cy_q[k]    <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        b_q[k]     <= b_d[k];
        sum_q[k]   <= sum_d[k];
        cy_q[k]    <= cy_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sumador_segmentado.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sumador_segmentado: directed + randomised checks of sumador_segmentado |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sumador_segmentado;

  logic clk = 1'b0;
  logic reset_L;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  logic       m_in_valid, m_in_ready, m_ci, m_sub, m_out_valid, m_out_ready, m_co, m_ovf;
  logic [7:0] m_a, m_b, m_s;

  sumador_segmentado #(.WIDTH(8), .STAGES(2), .PwrC(0)) u_dut (
    .clk(clk), .reset_L(reset_L),
    .in_valid(m_in_valid), .in_ready(m_in_ready),
    .a(m_a), .b(m_b), .ci(m_ci), .sub(m_sub),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .s(m_s), .co(m_co), .ovf(m_ovf)
  );

  logic       sw_in_valid [4];
  logic       sw_in_ready [4];
  logic       sw_out_valid[4];
  logic       sw_out_ready[4];
  logic       sw_co [4];
  logic       sw_ovf[4];
  logic [7:0] sw_s  [4];
  logic [7:0] sw_a, sw_b;
  logic       sw_ci, sw_sub;

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    sumador_segmentado #(.WIDTH(8), .STAGES(1 << g), .PwrC(g)) u_sw (
      .clk(clk), .reset_L(reset_L),
      .in_valid(sw_in_valid[g]), .in_ready(sw_in_ready[g]),
      .a(sw_a), .b(sw_b), .ci(sw_ci), .sub(sw_sub),
      .out_valid(sw_out_valid[g]), .out_ready(sw_out_ready[g]),
      .s(sw_s[g]), .co(sw_co[g]), .ovf(sw_ovf[g])
    );
  end

  // Reference: plain integer arithmetic; result packed as {ovf, co, s}.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic c, input logic sb);
    int ua, ub, sa, sy, ur, sr;
    logic cout, ov;
    ua = int'(x);
    ub = int'(y);
    sa = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      ur   = ua - ub;
      sr   = sa - sy;
      cout = (ua >= ub);
    end else begin
      ur   = ua + ub + int'(c);
      sr   = sa + sy + int'(c);
      cout = (ur > 255);
    end
    ov = (sr > 127) || (sr < -128);
    return {ov, cout, ur[7:0]};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] x, input logic [7:0] y, input logic c, input logic sb);
    m_in_valid = 1'b1;
    m_a = x; m_b = y; m_ci = c; m_sub = sb;
  endtask

  task automatic test_reset;
    reset_L = 1'b0;
    m_out_ready = 1'b0;
    #2;
    checks++;
    if ({m_out_valid, m_ovf, m_co, m_s, m_in_ready} !== {1'b0, 1'b0, 1'b0, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset_state got v=%b ovf=%b co=%b s=%h rdy=%b exp v=0 ovf=0 co=0 s=00 rdy=1",
               m_out_valid, m_ovf, m_co, m_s, m_in_ready);
    end
    m_in_valid = 1'b1;
    tick;
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept got out_valid=%b exp 0", m_out_valid);
    end
    m_in_valid = 1'b0;
    tick;
    reset_L = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vs [4];
    logic [9:0] ve [4];
    va = '{8'hFF, 8'h7F, 8'h05, 8'h80};
    vb = '{8'h01, 8'h01, 8'h07, 8'h80};
    vs = '{1'b0, 1'b0, 1'b1, 1'b0};
    ve = '{10'h100, 10'h280, 10'h0FE, 10'h300};
    m_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 1'b0, vs[i]);
      tick;
      m_in_valid = 1'b0;
      checks++;
      if (m_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL basic_latency[%0d] got out_valid=%b exp 0", i, m_out_valid);
      end
      tick;
      checks++;
      if ({m_out_valid, m_ovf, m_co, m_s} !== {1'b1, ve[i]}) begin
        errors++;
        $display("FAIL basic[%0d] got v=%b res=%h exp v=1 res=%h", i, m_out_valid, {m_ovf, m_co, m_s}, ve[i]);
      end
    end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic       vc [4];
    logic       vs [4];
    logic [9:0] ve [4];
    va = '{8'h10, 8'h30, 8'hF0, 8'h80};
    vb = '{8'h20, 8'h40, 8'h20, 8'h01};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1};
    ve = '{10'h030, 10'h070, 10'h111, 10'h37F};
    m_out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      if (cyc < 4) drive(va[cyc], vb[cyc], vc[cyc], vs[cyc]);
      else         m_in_valid = 1'b0;
      tick;
      if (cyc >= 1) begin
        checks++;
        if ({m_out_valid, m_ovf, m_co, m_s} !== {1'b1, ve[cyc-1]}) begin
          errors++;
          $display("FAIL b2b[%0d] got v=%b res=%h exp v=1 res=%h", cyc-1, m_out_valid, {m_ovf, m_co, m_s}, ve[cyc-1]);
        end
      end
    end
    tick;
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got out_valid=%b exp 0", m_out_valid);
    end
  endtask

  task automatic test_stall;
    m_out_ready = 1'b1;
    drive(8'h12, 8'h34, 1'b0, 1'b0);
    tick;
    drive(8'hC8, 8'h10, 1'b0, 1'b1);
    tick;
    m_out_ready = 1'b0;
    drive(8'h01, 8'h01, 1'b0, 1'b0);
    #1;
    checks++;
    if (m_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_in_ready got %b exp 0", m_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({m_out_valid, m_in_ready, m_ovf, m_co, m_s} !== {1'b1, 1'b0, 10'h046}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b rdy=%b res=%h exp v=1 rdy=0 res=046",
                 i, m_out_valid, m_in_ready, {m_ovf, m_co, m_s});
      end
    end
    m_in_valid  = 1'b0;
    m_out_ready = 1'b1;
    tick;
    checks++;
    if ({m_out_valid, m_ovf, m_co, m_s} !== {1'b1, 10'h1B8}) begin
      errors++;
      $display("FAIL stall_second got v=%b res=%h exp v=1 res=1b8", m_out_valid, {m_ovf, m_co, m_s});
    end
    tick;
    checks++;
    if (m_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_extra got out_valid=%b exp 0", m_out_valid);
    end
  endtask

  task automatic test_reset_midflight;
    m_out_ready = 1'b1;
    drive(8'h11, 8'h22, 1'b0, 1'b0);
    tick;
    drive(8'h33, 8'h44, 1'b0, 1'b0);
    tick;
    m_in_valid = 1'b0;
    reset_L = 1'b0;
    #1;
    checks++;
    if ({m_out_valid, m_ovf, m_co, m_s} !== 11'h000) begin
      errors++;
      $display("FAIL midreset_async got v=%b res=%h exp v=0 res=000", m_out_valid, {m_ovf, m_co, m_s});
    end
    tick;
    tick;
    reset_L = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++;
      if (m_out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale[%0d] got out_valid=%b exp 0", i, m_out_valid);
      end
    end
    drive(8'h01, 8'h01, 1'b0, 1'b0);
    tick;
    m_in_valid = 1'b0;
    tick;
    checks++;
    if ({m_out_valid, m_ovf, m_co, m_s} !== {1'b1, 10'h002}) begin
      errors++;
      $display("FAIL midreset_new got v=%b res=%h exp v=1 res=002", m_out_valid, {m_ovf, m_co, m_s});
    end
    tick;
  endtask

  task automatic test_random_sweep;
    logic [9:0] expq [4][$];
    logic [9:0] e;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      sw_a   = 8'($urandom);
      sw_b   = 8'($urandom);
      sw_ci  = 1'($urandom);
      sw_sub = 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        sw_in_valid[i]  = (cyc < 1950) ? ($urandom_range(0, 3) != 0) : 1'b0;
        sw_out_ready[i] = (cyc < 1950) ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
        if (sw_out_valid[i] === 1'b1 && sw_out_ready[i]) begin
          checks++;
          if (expq[i].size() == 0) begin
            errors++;
            $display("FAIL sweep_extra[st=%0d] got unexpected result %h exp none", 1 << i, {sw_ovf[i], sw_co[i], sw_s[i]});
          end else begin
            e = expq[i].pop_front();
            if ({sw_ovf[i], sw_co[i], sw_s[i]} !== e) begin
              errors++;
              $display("FAIL sweep[st=%0d] got res=%h exp res=%h", 1 << i, {sw_ovf[i], sw_co[i], sw_s[i]}, e);
            end
          end
        end
        if (sw_in_valid[i] && sw_in_ready[i] === 1'b1)
          expq[i].push_back(model(sw_a, sw_b, sw_ci, sw_sub));
      end
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (expq[i].size() != 0) begin
        errors++;
        $display("FAIL sweep_lost[st=%0d] got %0d pending exp 0", 1 << i, expq[i].size());
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_ci = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
    sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sw_in_valid[i]  = 1'b0;
      sw_out_ready[i] = 1'b1;
    end
    test_reset;
    test_basic;
    test_back_to_back;
    test_stall;
    test_reset_midflight;
    test_random_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
